// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet constants, transmit FSM states and CRC-32 step
// Used by both the RMII transmit framer and the receive path.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IPG
  } tx_state_t;

  // Reflected CRC-32 advanced by one dibit; d[0] is the earlier bit on the wire.
  function automatic logic [31:0] crc32_step2(input logic [31:0] crc, input logic [1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_dibit.sv
// rtl/crc32_dibit.sv - running Ethernet CRC-32, two bits per clock
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (crc -> CRC_INIT)
//   clear_i     reload CRC_INIT (wins over enable_i)
//   enable_i    fold data_i into the CRC this cycle
//   data_i      dibit, bit 0 first on the wire
//   crc_o       running CRC register (not inverted)
module crc32_dibit
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic [1:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = CRC_INIT;
    end else if (enable_i) begin
      crc_d = crc32_step2(crc_q, data_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/rmii_eth_tx.sv
// rtl/rmii_eth_tx.sv - RMII Ethernet transmit framer (preamble, SFD, data, pad, FCS, IPG)
// Ports:
//   clk, rst_n         50 MHz RMII reference clock, asynchronous active-low reset
//   tx_valid/tx_data/tx_last/tx_ready  byte stream in; consumed on tx_valid && tx_ready
//   eth_txd, eth_txen  RMII transmit pins (registered)
//   busy               frame start through end of IPG (registered)
//   underrun           one-cycle pulse when a frame is aborted (registered)
module rmii_eth_tx
  import eth_pkg::*;
#(
  parameter int MIN_PAYLOAD = 60,
  parameter int IPG_CYCLES  = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [1:0] eth_txd,
  output logic       eth_txen,
  output logic       busy,
  output logic       underrun
);

  // state_q always describes the dibit currently on the pins, so the pin
  // registers are loaded from the next-state view of the datapath.
  tx_state_t   state_q, state_d;
  logic [1:0]  dibit_cnt_q, dibit_cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  gp_cnt_q, gp_cnt_d;      // FCS dibit index, then IPG cycle count
  logic [7:0]  shift_q, shift_d;
  logic        last_q, last_d;          // byte on the pins was tagged tx_last
  logic [1:0]  txd_q, txd_d;
  logic        txen_q, txen_d;
  logic        busy_q, busy_d;
  logic        underrun_q, underrun_d;

  logic        crc_clear;
  logic        crc_en;
  logic [31:0] crc;
  logic [31:0] fcs;
  logic [10:0] byte_inc;

  assign byte_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
  assign fcs      = ~crc;

  assign tx_ready = ((state_q == ST_SFD) || (state_q == ST_DATA)) &&
                    (dibit_cnt_q == 2'd3) && !last_q;

  always_comb begin
    state_d     = state_q;
    dibit_cnt_d = dibit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    gp_cnt_d    = gp_cnt_q;
    shift_d     = shift_q;
    last_d      = last_q;
    underrun_d  = 1'b0;
    txd_d       = 2'b00;
    txen_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d     = ST_PREAMBLE;
          dibit_cnt_d = 2'd0;
          byte_cnt_d  = 11'd0;
          last_d      = 1'b0;
        end
      end
      ST_PREAMBLE: begin
        dibit_cnt_d = dibit_cnt_q + 2'd1;
        if (dibit_cnt_q == 2'd3) begin
          if (byte_cnt_q == 11'd6) begin
            state_d    = ST_SFD;
            byte_cnt_d = 11'd0;
          end else begin
            byte_cnt_d = byte_cnt_q + 11'd1;
          end
        end
      end
      ST_SFD, ST_DATA: begin
        dibit_cnt_d = dibit_cnt_q + 2'd1;
        if (dibit_cnt_q == 2'd3) begin
          if (tx_ready) begin
            if (tx_valid) begin
              state_d    = ST_DATA;
              shift_d    = tx_data;
              last_d     = tx_last;
              byte_cnt_d = byte_inc;
            end else begin
              // Source starved us mid-frame: abandon without an FCS.
              state_d    = ST_IPG;
              gp_cnt_d   = 8'd0;
              underrun_d = 1'b1;
            end
          end else if (byte_cnt_q < 11'(MIN_PAYLOAD)) begin
            state_d    = ST_PAD;
            byte_cnt_d = byte_inc;
          end else begin
            state_d  = ST_FCS;
            gp_cnt_d = 8'd0;
          end
        end
      end
      ST_PAD: begin
        dibit_cnt_d = dibit_cnt_q + 2'd1;
        if (dibit_cnt_q == 2'd3) begin
          if (byte_cnt_q >= 11'(MIN_PAYLOAD)) begin
            state_d  = ST_FCS;
            gp_cnt_d = 8'd0;
          end else begin
            byte_cnt_d = byte_inc;
          end
        end
      end
      ST_FCS: begin
        gp_cnt_d = gp_cnt_q + 8'd1;
        if (gp_cnt_q == 8'd15) begin
          state_d  = ST_IPG;
          gp_cnt_d = 8'd0;
        end
      end
      ST_IPG: begin
        gp_cnt_d = gp_cnt_q + 8'd1;
        if (gp_cnt_q == 8'(IPG_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_PREAMBLE: begin
        txen_d = 1'b1;
        txd_d  = PREAMBLE_BYTE[{dibit_cnt_d, 1'b0} +: 2];
      end
      ST_SFD: begin
        txen_d = 1'b1;
        txd_d  = SFD_BYTE[{dibit_cnt_d, 1'b0} +: 2];
      end
      ST_DATA: begin
        txen_d = 1'b1;
        txd_d  = shift_d[{dibit_cnt_d, 1'b0} +: 2];
      end
      ST_PAD: begin
        txen_d = 1'b1;
        txd_d  = 2'b00;
      end
      ST_FCS: begin
        // CRC is frozen after the last pad/data dibit; send ~crc LSB first.
        txen_d = 1'b1;
        txd_d  = fcs[{gp_cnt_d[3:0], 1'b0} +: 2];
      end
      default: begin
        txen_d = 1'b0;
        txd_d  = 2'b00;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // The CRC follows exactly the data/pad dibits being loaded onto the pins.
  assign crc_clear = (state_q == ST_IDLE);
  assign crc_en    = (state_d == ST_DATA) || (state_d == ST_PAD);

  crc32_dibit u_crc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (crc_clear),
    .enable_i (crc_en),
    .data_i   (txd_d),
    .crc_o    (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dibit_cnt_q <= 2'd0;
      byte_cnt_q  <= 11'd0;
      gp_cnt_q    <= 8'd0;
      shift_q     <= 8'd0;
      last_q      <= 1'b0;
      txd_q       <= 2'b00;
      txen_q      <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dibit_cnt_q <= dibit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      gp_cnt_q    <= gp_cnt_d;
      shift_q     <= shift_d;
      last_q      <= last_d;
      txd_q       <= txd_d;
      txen_q      <= txen_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
    end
  end

  assign eth_txd  = txd_q;
  assign eth_txen = txen_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_rmii_eth_tx.sv
// tb/tb_rmii_eth_tx.sv - self-checking bench for rmii_eth_tx and crc32_dibit
module tb_rmii_eth_tx;
  import eth_pkg::*;

  localparam int MIN_PAY = 60;

  logic       clk;
  logic       rst_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic [1:0] eth_txd;
  logic       eth_txen;
  logic       busy;
  logic       underrun;

  logic        crc_clr;
  logic        crc_en;
  logic [1:0]  crc_din;
  logic [31:0] crc_out;

  int errors = 0;
  int checks = 0;

  logic [7:0]  pay [0:255];
  logic [7:0]  exp_b[$];
  logic [31:0] exp_fcs;
  logic [1:0]  cap[$];
  int          runs[$];
  int          gaps[$];
  bit          mon_prev = 0;
  bit          mon_seen = 0;
  int          mon_run = 0;
  int          mon_gap = 0;

  rmii_eth_tx #(.MIN_PAYLOAD(60), .IPG_CYCLES(48)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .eth_txd  (eth_txd),
    .eth_txen (eth_txen),
    .busy     (busy),
    .underrun (underrun)
  );

  crc32_dibit u_crc_unit (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (crc_clr),
    .enable_i (crc_en),
    .data_i   (crc_din),
    .crc_o    (crc_out)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Pin monitor: collects dibits while eth_txen is high, txen-high run lengths
  // and txen-low gaps between frames.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_prev = 0;
        mon_run  = 0;
      end else if (eth_txen) begin
        cap.push_back(eth_txd);
        if (!mon_prev && mon_seen) gaps.push_back(mon_gap);
        mon_gap  = 0;
        mon_run++;
        mon_prev = 1;
      end else begin
        if (mon_prev) begin
          runs.push_back(mon_run);
          mon_run  = 0;
          mon_seen = 1;
        end
        mon_gap++;
        mon_prev = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sw_crc(input logic [31:0] c_in, input logic [7:0] b_in);
    logic [31:0] c;
    logic [7:0]  b;
    c = c_in;
    b = b_in;
    for (int k = 0; k < 8; k++) begin
      if ((c[0] ^ b[0]) == 1'b1) c = (c >> 1) ^ CRC_POLY;
      else                       c = c >> 1;
      b = b >> 1;
    end
    return c;
  endfunction

  // Reference frame as bytes: preamble, SFD, payload, zero pad, FCS LSB first.
  task automatic build_frame(input int base, input int n);
    logic [31:0] c;
    for (int k = 0; k < 7; k++) exp_b.push_back(8'h55);
    exp_b.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) begin
      exp_b.push_back(pay[base + k]);
      c = sw_crc(c, pay[base + k]);
    end
    for (int k = n; k < MIN_PAY; k++) begin
      exp_b.push_back(8'h00);
      c = sw_crc(c, 8'h00);
    end
    exp_fcs = ~c;
    for (int k = 0; k < 4; k++) exp_b.push_back(exp_fcs[8*k +: 8]);
  endtask

  function automatic logic [7:0] dec_byte(input int idx);
    return {cap[4*idx+3], cap[4*idx+2], cap[4*idx+1], cap[4*idx]};
  endfunction

  task automatic clear_mon();
    #1;
    cap.delete();
    runs.delete();
    gaps.delete();
    exp_b.delete();
    mon_seen = 0;
    mon_run  = 0;
    mon_gap  = 0;
  endtask

  task automatic check_dibits(input string tag, input int nd);
    int bad;
    int lim;
    logic [7:0] b;
    logic [1:0] e;
    bad = 0;
    chk({tag, "_dibit_count"}, cap.size(), nd);
    lim = (cap.size() < nd) ? cap.size() : nd;
    for (int i = 0; i < lim; i++) begin
      b = exp_b[i/4];
      e = 2'(b >> (2*(i%4)));
      if (cap[i] !== e) bad++;
    end
    chk({tag, "_dibit_errors"}, bad, 0);
  endtask

  task automatic check_frame(input string tag, input int run_exp);
    int nb;
    logic [31:0] c;
    logic [31:0] obs_fcs;
    check_dibits(tag, exp_b.size() * 4);
    chk({tag, "_runs"}, runs.size(), 1);
    chk({tag, "_txen_cycles"}, (runs.size() > 0) ? runs[0] : 0, run_exp);
    nb = cap.size() / 4;
    obs_fcs = 32'h0;
    c = CRC_INIT;
    if (nb >= 12) begin
      for (int k = 0; k < 4; k++) obs_fcs[8*k +: 8] = dec_byte(nb - 4 + k);
      for (int i = 8; i < nb; i++) c = sw_crc(c, dec_byte(i));
    end
    chk({tag, "_fcs"}, obs_fcs, exp_fcs);
    chk({tag, "_residue"}, c, CRC_RESIDUE);
  endtask

  task automatic drive(input int base, input int n, input int drop_at, input int rst_at, input bit keep);
    int i;
    int cyc;
    bit to;
    i = 0;
    cyc = 0;
    to = 0;
    tx_valid = 1'b1;
    tx_data  = pay[base];
    tx_last  = (n == 1);
    while (i < n) begin
      @(negedge clk);
      cyc++;
      if (cyc > 5000) begin
        to = 1;
        break;
      end
      if (tx_ready) begin
        if (i == drop_at) begin
          tx_valid = 1'b0;
          break;
        end
        @(posedge clk);
        #1;
        i++;
        if (i < n) begin
          tx_data = pay[base + i];
          tx_last = (i == n - 1);
        end else begin
          tx_valid = keep;
          tx_last  = 1'b0;
          tx_data  = keep ? pay[base + n] : 8'h00;
        end
        if (i == rst_at) break;
      end
    end
    chk("drive_timeout", {31'd0, to}, 32'd0);
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((busy || eth_txen) && cyc < 3000);
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    crc_clr  = 1'b0;
    crc_en   = 1'b0;
    crc_din  = 2'b00;
    repeat (4) @(negedge clk);
    chk("reset_txen", eth_txen, 0);
    chk("reset_txd", eth_txd, 0);
    chk("reset_busy", busy, 0);
    chk("reset_underrun", underrun, 0);
    chk("reset_tx_ready", tx_ready, 0);
    rst_n = 1'b1;

    // CRC unit: "123456789" LSB dibit first.
    @(negedge clk);
    crc_clr = 1'b1;
    @(negedge clk);
    crc_clr = 1'b0;
    crc_en  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] ch;
      ch = 8'h31 + 8'(k);
      for (int j = 0; j < 4; j++) begin
        crc_din = ch[2*j +: 2];
        @(negedge clk);
      end
    end
    crc_en = 1'b0;
    chk("crc32_unit_check", ~crc_out, 32'hCBF43926);

    // 60-byte frame 0x00..0x3B.
    clear_mon();
    for (int k = 0; k < 60; k++) pay[k] = 8'(k);
    build_frame(0, 60);
    drive(0, 60, -1, -1, 1'b0);
    wait_idle();
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
        if (i >= cap.size()) bad++;
        else if (cap[i] !== ((i == 31) ? 2'b11 : 2'b01)) bad++;
      end
      chk("f60_preamble_sfd", bad, 0);
    end
    check_frame("f60", 288);

    // 14-byte frame: padded to 60.
    clear_mon();
    for (int k = 0; k < 14; k++) pay[k] = 8'($urandom);
    build_frame(0, 14);
    drive(0, 14, -1, -1, 1'b0);
    wait_idle();
    check_frame("f14_pad", 288);

    // Single-byte frame: tx_last on the first byte.
    clear_mon();
    pay[0] = 8'($urandom);
    build_frame(0, 1);
    drive(0, 1, -1, -1, 1'b0);
    wait_idle();
    check_frame("f1_pad", 288);

    // Random length above the minimum.
    clear_mon();
    n = int'($urandom_range(61, 90));
    for (int k = 0; k < n; k++) pay[k] = 8'($urandom);
    build_frame(0, n);
    drive(0, n, -1, -1, 1'b0);
    wait_idle();
    check_frame("frand", 48 + 4*n);

    // Underrun when byte 20 is requested.
    clear_mon();
    for (int k = 0; k < 30; k++) pay[k] = 8'($urandom);
    build_frame(0, 30);
    drive(0, 30, 19, -1, 1'b0);
    @(negedge clk);
    chk("urun_txen_low", eth_txen, 0);
    chk("urun_pulse", underrun, 1);
    @(negedge clk);
    chk("urun_pulse_end", underrun, 0);
    repeat (46) @(negedge clk);
    chk("urun_busy_held", busy, 1);
    @(negedge clk);
    chk("urun_busy_fall", busy, 0);
    check_dibits("urun", 32 + 4*19);
    chk("urun_txen_cycles", (runs.size() > 0) ? runs[0] : 0, 32 + 4*19);
    wait_idle();

    // Two 64-byte frames back to back with tx_valid held.
    clear_mon();
    for (int k = 0; k < 129; k++) pay[k] = 8'($urandom);
    build_frame(0, 64);
    build_frame(64, 64);
    drive(0, 64, -1, -1, 1'b1);
    drive(64, 64, -1, -1, 1'b0);
    wait_idle();
    check_dibits("b2b", exp_b.size() * 4);
    chk("b2b_runs", runs.size(), 2);
    chk("b2b_run0", (runs.size() > 0) ? runs[0] : 0, 304);
    chk("b2b_run1", (runs.size() > 1) ? runs[1] : 0, 304);
    chk("b2b_gaps", gaps.size(), 1);
    chk("b2b_gap", (gaps.size() > 0) ? gaps[0] : 0, 49);

    // Reset during payload byte 10, then a clean frame.
    clear_mon();
    for (int k = 0; k < 60; k++) pay[k] = 8'($urandom);
    drive(0, 60, -1, 10, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_txen_before", eth_txen, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_txen", eth_txen, 0);
    chk("rst_mid_txd", eth_txd, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_underrun", underrun, 0);
    chk("rst_mid_tx_ready", tx_ready, 0);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_after_underrun", underrun, 0);
    clear_mon();
    for (int k = 0; k < 60; k++) pay[k] = 8'($urandom);
    build_frame(0, 60);
    drive(0, 60, -1, -1, 1'b0);
    wait_idle();
    check_frame("post_rst", 288);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
